// File: rtl/memory_stage_if.sv
// EX/MEM in, MEM/WB out and the 16-bit req/ack data-memory port of the memory stage.
// The slave modport is the stage itself; the master modport is execute/writeback/memory.
// Stall is the only backpressure signal toward execute; memory paces the stage with ack.
interface memory_stage_if #(
  parameter int ADDR_W = 20
);
  logic              enable;
  logic [75:0]       in_bus;
  logic              in_valid;
  logic              stall;
  logic [36:0]       out_bus;
  logic              out_valid;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  enable, in_bus, in_valid, mem_rdata, mem_ack,
    output stall, out_bus, out_valid, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output enable, in_bus, in_valid, mem_rdata, mem_ack,
    input  stall, out_bus, out_valid, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: performs the data-memory access for one EX/MEM instruction and emits MEM/WB.
// Latency: 1 edge for non-memory ops, 2+ edges for reads/writes (MAX_WAIT cycles max, then Err).
// Backpressure: stall is high whenever an access is outstanding; enable=0 freezes everything.
module memory_stage #(
  parameter int ADDR_W   = 20,
  parameter int MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  // Fields of the instruction in flight, needed to build MEM/WB when the access ends.
  logic [15:0]       alu_q;
  logic [2:0]        rdst_q;
  logic              wb_q;
  logic              rd_q;

  // EX/MEM bus fields.
  logic [31:0]       in_sp;
  logic [15:0]       in_store;
  logic [15:0]       in_alu;
  logic [2:0]        in_rdst;
  logic [1:0]        in_memop;
  logic [1:0]        in_spop;
  logic              in_wb;
  logic              in_is_mem;
  logic [ADDR_W-1:0] in_addr;
  logic              unused_bits;

  assign in_sp     = bus.in_bus[75:44];
  assign in_store  = bus.in_bus[43:28];
  assign in_alu    = bus.in_bus[27:12];
  assign in_rdst   = bus.in_bus[8:6];
  assign in_memop  = bus.in_bus[5:4];
  assign in_spop   = bus.in_bus[3:2];
  assign in_wb     = bus.in_bus[1];

  // Rsrc and LDD are decoded upstream; only their presence on the bus matters here.
  assign unused_bits = ^{bus.in_bus[11:9], bus.in_bus[0], in_sp};

  // Reserved op 11 behaves like "no memory op".
  assign in_is_mem = (in_memop == 2'b01) || (in_memop == 2'b10);

  // Stack operations address through SP; everything else uses the ALU result.
  assign in_addr = (in_spop != 2'b00) ? in_sp[ADDR_W-1:0] : ADDR_W'(in_alu);

  assign bus.stall = (state != IDLE);

  // Stage FSM: capture in IDLE, hold the request in ACCESS until ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      alu_q         <= '0;
      rdst_q        <= '0;
      wb_q          <= 1'b0;
      rd_q          <= 1'b0;
      bus.out_bus   <= '0;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (bus.enable) begin
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            alu_q  <= in_alu;
            rdst_q <= in_rdst;
            wb_q   <= in_wb;
            rd_q   <= (in_memop == 2'b01);
            if (in_is_mem) begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= (in_memop == 2'b10);
              bus.mem_addr  <= in_addr;
              bus.mem_wdata <= in_store;
              wait_cnt      <= '0;
              state         <= ACCESS;
            end else begin
              bus.out_bus   <= {16'h0000, in_alu, in_rdst, in_wb, 1'b0};
              bus.out_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            // Ack wins even on the last allowed cycle.
            bus.mem_req   <= 1'b0;
            bus.out_bus   <= {(rd_q ? bus.mem_rdata : 16'h0000), alu_q, rdst_q, wb_q, rd_q};
            bus.out_valid <= 1'b1;
            state         <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            // Timed-out access retires with WB cleared so the register file is untouched.
            bus.mem_req   <= 1'b0;
            bus.out_bus   <= {16'h0000, alu_q, rdst_q, 1'b0, 1'b0};
            bus.out_valid <= 1'b1;
            bus.err       <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized instructions.
// Expected results come from a transaction-level model of the stage's retirement rules.
// Memory ack timing is driven per instruction; junk is driven on ignored inputs.
module tb_memory_stage;

  localparam int ADDR_W   = 20;
  localparam int MAX_WAIT = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  memory_stage_if #(.ADDR_W(ADDR_W)) ifc ();

  memory_stage #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [75:0] pack(input logic [31:0] sp, input logic [15:0] store,
                                       input logic [15:0] alu, input logic [2:0] rdst,
                                       input logic [1:0] memop, input logic [1:0] spop,
                                       input logic wb);
    logic [2:0] rsrc;
    rsrc = 3'($urandom);
    return {sp, store, alu, rsrc, rdst, memop, spop, wb, 1'($urandom)};
  endfunction

  // Reference: what one instruction should look like once it retires.
  // d = memory cycle index at which ack arrives (0 = first access cycle), -1 = never.
  function automatic void model(input logic [75:0] ins, input int d, input logic [15:0] rdata,
                                output int lat, output int stl, output logic [36:0] out,
                                output logic err, output logic [ADDR_W-1:0] addr);
    logic [1:0] op;
    logic       rd;
    op   = ins[5:4];
    rd   = (op == 2'b01);
    addr = (ins[3:2] != 2'b00) ? ins[44 +: ADDR_W] : ADDR_W'(ins[27:12]);
    if (op == 2'b01 || op == 2'b10) begin
      if (d >= 0 && d < MAX_WAIT) begin
        lat = d + 2;
        stl = d + 1;
        out = {(rd ? rdata : 16'h0000), ins[27:12], ins[8:6], ins[1], rd};
        err = 1'b0;
      end else begin
        lat = MAX_WAIT + 1;
        stl = MAX_WAIT;
        out = {16'h0000, ins[27:12], ins[8:6], 2'b00};
        err = 1'b1;
      end
    end else begin
      lat = 1;
      stl = 0;
      out = {16'h0000, ins[27:12], ins[8:6], ins[1], 1'b0};
      err = 1'b0;
    end
  endfunction

  // Issue one instruction from IDLE and play the memory side until it retires.
  // Ends sampled just after the retiring edge; lat = -1 if it never retired.
  task automatic run_instr(input logic [75:0] ins, input int d, input logic [15:0] rdata,
                           output int lat, output int stl, output logic [36:0] out,
                           output logic err, output logic [ADDR_W-1:0] addr,
                           output logic we, output logic [15:0] wdata, output logic stable);
    int k;
    bit done;
    lat = 0; stl = 0; out = '0; err = 1'b0; addr = '0; we = 1'b0; wdata = '0; stable = 1'b1;
    k = 0; done = 1'b0;
    ifc.enable    = 1'b1;
    ifc.in_bus    = ins;
    ifc.in_valid  = 1'b1;
    ifc.mem_ack   = 1'($urandom);
    ifc.mem_rdata = 16'($urandom);
    step();
    lat = 1;
    ifc.in_valid = 1'b0;
    ifc.in_bus   = 76'({$urandom, $urandom, $urandom});
    while (!done && lat < 40) begin
      if (ifc.out_valid) begin
        out  = ifc.out_bus;
        err  = ifc.err;
        done = 1'b1;
        if (ifc.stall) stl = stl + 100;
        ifc.in_valid = 1'b0;
        ifc.mem_ack  = 1'b0;
      end else begin
        if (ifc.stall) begin
          stl++;
          if (k == 0) begin
            addr  = ifc.mem_addr;
            we    = ifc.mem_we;
            wdata = ifc.mem_wdata;
            if (ifc.mem_req !== 1'b1) stable = 1'b0;
          end else if (ifc.mem_addr !== addr || ifc.mem_we !== we ||
                       ifc.mem_wdata !== wdata || ifc.mem_req !== 1'b1) begin
            stable = 1'b0;
          end
          ifc.mem_ack   = (k == d);
          ifc.mem_rdata = (k == d) ? rdata : 16'($urandom);
          ifc.in_valid  = 1'($urandom);
          k++;
        end else begin
          ifc.mem_ack = 1'b0;
        end
        step();
        lat++;
      end
    end
    ifc.mem_ack = 1'b0;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    logic [75:0] ins;
    int lat, stl; logic [36:0] out; logic err, we, st; logic [ADDR_W-1:0] addr; logic [15:0] wd;
    rst_n = 1'b0;
    ifc.enable = 1'b1; ifc.in_valid = 1'b0; ifc.in_bus = '0; ifc.mem_ack = 1'b0; ifc.mem_rdata = '0;
    #3;
    checks++;
    if ({ifc.out_bus, ifc.out_valid, ifc.err, ifc.mem_req, ifc.mem_we, ifc.mem_addr,
         ifc.mem_wdata, ifc.stall} !== '0) begin
      failures++;
      $display("FAIL reset_state: out=%h vld=%b err=%b req=%b we=%b addr=%h wdata=%h stall=%b, want all 0",
               ifc.out_bus, ifc.out_valid, ifc.err, ifc.mem_req, ifc.mem_we, ifc.mem_addr,
               ifc.mem_wdata, ifc.stall);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    // Leave a nonzero Out behind, then start a read and reset in the middle of it.
    ins = pack(32'h1, 16'h2, 16'hFFFF, 3'd7, 2'b00, 2'b00, 1'b1);
    run_instr(ins, -1, 16'h0, lat, stl, out, err, addr, we, wd, st);
    ins = pack(32'h0, 16'h0, 16'h0123, 3'd1, 2'b01, 2'b00, 1'b1);
    ifc.in_bus = ins; ifc.in_valid = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    step();
    checks++;
    if (ifc.mem_req !== 1'b1 || ifc.stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_access: req=%b stall=%b, want 1 1", ifc.mem_req, ifc.stall);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.mem_req !== 1'b0 || ifc.out_bus !== '0 || ifc.out_valid !== 1'b0 || ifc.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_access: req=%b out=%h vld=%b stall=%b, want 0 0 0 0",
               ifc.mem_req, ifc.out_bus, ifc.out_valid, ifc.stall);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_op_none();
    logic [75:0] ins;
    int lat, stl; logic [36:0] out; logic err, we, st; logic [ADDR_W-1:0] addr; logic [15:0] wd;
    ins = pack($urandom, 16'($urandom), 16'h1234, 3'd5, 2'b00, 2'($urandom), 1'b1);
    run_instr(ins, -1, 16'h0, lat, stl, out, err, addr, we, wd, st);
    checks++;
    if (lat !== 1 || stl !== 0) begin
      failures++;
      $display("FAIL none_timing: latency=%0d stall_cycles=%0d, want 1 0", lat, stl);
    end
    checks++;
    if (out !== {16'h0000, 16'h1234, 3'd5, 1'b1, 1'b0} || err !== 1'b0) begin
      failures++;
      $display("FAIL none_out: out=%h err=%b, want %h 0", out, err, {16'h0000, 16'h1234, 3'd5, 1'b1, 1'b0});
    end
    step();
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_bus !== {16'h0000, 16'h1234, 3'd5, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL none_pulse_hold: vld=%b out=%h, want 0 and held value", ifc.out_valid, ifc.out_bus);
    end
  endtask

  task automatic test_read_sp();
    logic [75:0] ins;
    int lat, stl; logic [36:0] out; logic err, we, st; logic [ADDR_W-1:0] addr; logic [15:0] wd;
    ins = pack(32'h000F_FFFE, 16'($urandom), 16'h0777, 3'd2, 2'b01, 2'b01, 1'b1);
    run_instr(ins, 3, 16'hBEEF, lat, stl, out, err, addr, we, wd, st);
    checks++;
    if (addr !== 20'hFFFFE || we !== 1'b0 || st !== 1'b1) begin
      failures++;
      $display("FAIL read_port: addr=%h we=%b stable=%b, want FFFFE 0 1", addr, we, st);
    end
    checks++;
    if (stl !== 4 || lat !== 5) begin
      failures++;
      $display("FAIL read_timing: stall_cycles=%0d latency=%0d, want 4 5", stl, lat);
    end
    checks++;
    if (out[36:21] !== 16'hBEEF || out[0] !== 1'b1 || err !== 1'b0 || ifc.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL read_out: data=%h memtoreg=%b err=%b req=%b, want BEEF 1 0 0",
               out[36:21], out[0], err, ifc.mem_req);
    end
  endtask

  task automatic test_write();
    logic [75:0] ins;
    int lat, stl; logic [36:0] out; logic err, we, st; logic [ADDR_W-1:0] addr; logic [15:0] wd;
    ins = pack(32'hDEAD_BEEF, 16'hA5A5, 16'h0040, 3'd3, 2'b10, 2'b00, 1'b0);
    run_instr(ins, 0, 16'h5555, lat, stl, out, err, addr, we, wd, st);
    checks++;
    if (addr !== 20'h00040 || we !== 1'b1 || wd !== 16'hA5A5) begin
      failures++;
      $display("FAIL write_port: addr=%h we=%b wdata=%h, want 00040 1 A5A5", addr, we, wd);
    end
    checks++;
    if (lat !== 2 || out[0] !== 1'b0 || out[36:21] !== 16'h0000 || err !== 1'b0) begin
      failures++;
      $display("FAIL write_out: latency=%0d memtoreg=%b data=%h err=%b, want 2 0 0000 0",
               lat, out[0], out[36:21], err);
    end
  endtask

  task automatic test_timeout();
    logic [75:0] ins;
    int lat, stl; logic [36:0] out; logic err, we, st; logic [ADDR_W-1:0] addr; logic [15:0] wd;
    ins = pack(32'h0, 16'h0, 16'h0ABC, 3'd6, 2'b01, 2'b00, 1'b1);
    run_instr(ins, -1, 16'h0, lat, stl, out, err, addr, we, wd, st);
    checks++;
    if (stl !== MAX_WAIT || lat !== MAX_WAIT + 1 || st !== 1'b1) begin
      failures++;
      $display("FAIL timeout_timing: req_cycles=%0d latency=%0d stable=%b, want %0d %0d 1",
               stl, lat, st, MAX_WAIT, MAX_WAIT + 1);
    end
    checks++;
    if (err !== 1'b1 || out !== {16'h0000, 16'h0ABC, 3'd6, 2'b00} || ifc.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_out: err=%b out=%h req=%b, want 1 %h 0", err, out, ifc.mem_req,
               {16'h0000, 16'h0ABC, 3'd6, 2'b00});
    end
    step();
    checks++;
    if (ifc.err !== 1'b0 || ifc.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: err=%b vld=%b, want 0 0", ifc.err, ifc.out_valid);
    end
    run_instr(ins, MAX_WAIT - 1, 16'h1357, lat, stl, out, err, addr, we, wd, st);
    checks++;
    if (err !== 1'b0 || lat !== MAX_WAIT + 1 || out[1] !== 1'b1 || out[36:21] !== 16'h1357) begin
      failures++;
      $display("FAIL ack_at_limit: err=%b latency=%0d wb=%b data=%h, want 0 %0d 1 1357",
               err, lat, out[1], out[36:21], MAX_WAIT + 1);
    end
  endtask

  task automatic test_enable_freeze();
    logic [75:0] ins;
    logic [ADDR_W-1:0] a0;
    // No capture while disabled in IDLE.
    ifc.enable = 1'b0;
    ifc.in_bus = pack(32'h0, 16'h0, 16'h4444, 3'd4, 2'b00, 2'b00, 1'b1);
    ifc.in_valid = 1'b1;
    step(); step();
    ifc.in_valid = 1'b0;
    ifc.enable = 1'b1;
    step();
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_bus[20:5] === 16'h4444) begin
      failures++;
      $display("FAIL idle_freeze: vld=%b alu=%h, want no capture", ifc.out_valid, ifc.out_bus[20:5]);
    end
    // Freeze a read part-way through its wait window; the counter must not advance.
    ins = pack(32'h0003_1234, 16'h0, 16'h0999, 3'd1, 2'b01, 2'b11, 1'b1);
    ifc.in_bus = ins; ifc.in_valid = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    a0 = ifc.mem_addr;
    for (int i = 0; i < 5; i++) step();
    ifc.enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ifc.mem_ack   = (i == 2);
      ifc.mem_rdata = 16'h7E57;
      step();
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.stall !== 1'b1 || ifc.mem_req !== 1'b1 || ifc.mem_addr !== a0) begin
        failures++;
        $display("FAIL enable_freeze[%0d]: vld=%b stall=%b req=%b addr=%h, want 0 1 1 %h",
                 i, ifc.out_valid, ifc.stall, ifc.mem_req, ifc.mem_addr, a0);
      end
    end
    ifc.enable = 1'b1;
    ifc.mem_ack = 1'b1;
    step();
    ifc.mem_ack = 1'b0;
    checks++;
    if (a0 !== 20'h31234 || ifc.out_valid !== 1'b1 || ifc.err !== 1'b0 || ifc.out_bus[36:21] !== 16'h7E57 ||
        ifc.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL enable_resume: addr=%h vld=%b err=%b data=%h req=%b, want 31234 1 0 7E57 0",
               a0, ifc.out_valid, ifc.err, ifc.out_bus[36:21], ifc.mem_req);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [75:0] ins;
    logic [36:0] exp_out;
    int lat, stl; logic err; logic [ADDR_W-1:0] addr;
    for (int i = 0; i < 5; i++) begin
      ins = pack($urandom, 16'($urandom), 16'($urandom), 3'($urandom), (i % 2 == 0) ? 2'b00 : 2'b11,
                 2'($urandom), 1'($urandom));
      model(ins, -1, 16'h0, lat, stl, exp_out, err, addr);
      ifc.in_bus = ins; ifc.in_valid = 1'b1; ifc.enable = 1'b1;
      step();
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_bus !== exp_out || ifc.stall !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back[%0d]: vld=%b out=%h stall=%b, want 1 %h 0",
                 i, ifc.out_valid, ifc.out_bus, ifc.stall, exp_out);
      end
    end
    ifc.in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [75:0] ins;
    int d, lat, stl, e_lat, e_stl;
    logic [36:0] out, e_out;
    logic err, e_err, we, st;
    logic [ADDR_W-1:0] addr, e_addr;
    logic [15:0] wd, rdata;
    for (int n = 0; n < 40; n++) begin
      ins = 76'({$urandom, $urandom, $urandom});
      d = $urandom_range(0, 10);
      if (d == 10) d = -1;
      rdata = 16'($urandom);
      model(ins, d, rdata, e_lat, e_stl, e_out, e_err, e_addr);
      run_instr(ins, d, rdata, lat, stl, out, err, addr, we, wd, st);
      checks++;
      if (lat !== e_lat || stl !== e_stl || out !== e_out || err !== e_err || ifc.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL random[%0d] op=%b d=%0d: lat=%0d stall=%0d out=%h err=%b req=%b, want %0d %0d %h %b 0",
                 n, ins[5:4], d, lat, stl, out, err, ifc.mem_req, e_lat, e_stl, e_out, e_err);
      end
      if (ins[5:4] == 2'b01 || ins[5:4] == 2'b10) begin
        checks++;
        if (addr !== e_addr || we !== (ins[5:4] == 2'b10) || wd !== ins[43:28] || st !== 1'b1) begin
          failures++;
          $display("FAIL random_port[%0d]: addr=%h we=%b wdata=%h stable=%b, want %h %b %h 1",
                   n, addr, we, wd, st, e_addr, ins[5:4] == 2'b10, ins[43:28]);
        end
      end
      if ($urandom_range(0, 2) == 0) step();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_op_none();
    test_read_sp();
    test_write();
    test_timeout();
    test_enable_freeze();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
